// File: rtl/snake_dir_ctrl_if.sv
// Signal bundle between the snake game core (master) and the direction input stage (slave).
// Button inputs and step ticks come from the core side; direction and status flags go back to it.
interface snake_dir_ctrl_if #(
   parameter int unsigned QUEUE_DEPTH = 2
);
   localparam int unsigned QW = $clog2(QUEUE_DEPTH + 1);

   logic          ena;
   logic [3:0]    btn_i;
   logic          move_tick_i;
   logic [1:0]    dir_o;
   logic          turn_o;
   logic          drop_o;
   logic [3:0]    btn_db_o;
   logic [QW-1:0] q_count_o;

   modport master (
      output ena, btn_i, move_tick_i,
      input  dir_o, turn_o, drop_o, btn_db_o, q_count_o
   );

   modport slave (
      input  ena, btn_i, move_tick_i,
      output dir_o, turn_o, drop_o, btn_db_o, q_count_o
   );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction input stage: button synchroniser, per-button debounce, press-edge detection,
// turn queue between game steps and 180-degree reversal filtering.
module snake_dir_ctrl #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DEB_LIMIT     = 50000,
   parameter int unsigned QUEUE_DEPTH   = 2,
   parameter bit          ALLOW_REVERSE = 1'b0,
   parameter logic [1:0]  INIT_DIR      = 2'b11
) (
   input logic             clk,
   input logic             rst_n,
   snake_dir_ctrl_if.slave bus
);
   localparam int unsigned CW = (DEB_LIMIT > 2) ? $clog2(DEB_LIMIT) : 1;
   localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned QW = $clog2(QUEUE_DEPTH + 1);

   logic [3:0]    sync_q [SYNC_STAGES];
   logic [3:0]    synced;
   logic [CW-1:0] deb_cnt [4];
   logic [3:0]    btn_db;
   logic [3:0]    deb_diff;
   logic [3:0]    deb_flip;
   logic [3:0]    rise;

   logic          press_vld;
   logic [1:0]    press_dir;

   logic [1:0]    q_mem [QUEUE_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [QW-1:0] q_count;
   logic [1:0]    tail_dir;
   logic [1:0]    dir;
   logic          turn;
   logic          drop;

   logic          q_empty;
   logic          q_full;
   logic [1:0]    ref_dir;
   logic          pop;
   logic          evt;
   logic          rev_blk;
   logic          push;
   logic          reject;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // ---------------- synchroniser ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.btn_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // ---------------- debounce ----------------
   always_comb begin
      deb_diff = '0;
      deb_flip = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         deb_diff[i] = synced[i] != btn_db[i];
         deb_flip[i] = deb_diff[i] && (deb_cnt[i] == CW'(DEB_LIMIT - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_db <= '0;
         for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!deb_diff[i] || deb_flip[i]) deb_cnt[i] <= '0;
            else                             deb_cnt[i] <= deb_cnt[i] + CW'(1);
            if (deb_flip[i]) btn_db[i] <= synced[i];
         end
      end
   end

   // Rise is taken from the debounce next-state so the press is handled on the same edge
   // that btn_db_o goes high, saving a delay flop.
   assign rise = deb_flip & ~btn_db;

   // Priority up > down > left > right; direction code is 3 minus the button bit index.
   always_comb begin
      press_vld = |rise;
      press_dir = 2'b11;
      if      (rise[3]) press_dir = 2'b00;
      else if (rise[2]) press_dir = 2'b01;
      else if (rise[1]) press_dir = 2'b10;
   end

   // ---------------- turn queue control ----------------
   always_comb begin
      q_empty = q_count == '0;
      q_full  = q_count == QW'(QUEUE_DEPTH);
      ref_dir = q_empty ? dir : tail_dir;
      pop     = bus.ena && bus.move_tick_i && !q_empty;
      evt     = bus.ena && press_vld && (press_dir != ref_dir);
      rev_blk = !ALLOW_REVERSE && (press_dir == (ref_dir ^ 2'b01));
      push    = evt && !rev_blk && !(q_full && !pop);
      reject  = evt && !push;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
         head     <= '0;
         tail     <= '0;
         q_count  <= '0;
         tail_dir <= INIT_DIR;
         dir      <= INIT_DIR;
         turn     <= 1'b0;
         drop     <= 1'b0;
      end else begin
         if (push) begin
            q_mem[tail] <= press_dir;
            tail        <= ptr_inc(tail);
            tail_dir    <= press_dir;
         end
         if (pop) begin
            dir  <= q_mem[head];
            head <= ptr_inc(head);
         end
         if (push && !pop)      q_count <= q_count + QW'(1);
         else if (pop && !push) q_count <= q_count - QW'(1);
         turn <= pop && (q_mem[head] != dir);
         drop <= reject;
      end
   end

   assign bus.dir_o     = dir;
   assign bus.turn_o    = turn;
   assign bus.drop_o    = drop;
   assign bus.btn_db_o  = btn_db;
   assign bus.q_count_o = q_count;

endmodule
